spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// Command decoder behind an SPI slave: opcodes arrive as 16-bit words, replies leave as 16-bit words.
// One-cycle consume/ack per word; TX writes wait on wr_buffer_free, one word in flight.
module spi_cmd_ctrl #(
    parameter int DATA_W = 16,
    parameter int VEC_N  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ss,
    input  logic                  i_rd_data_available,
    input  logic [DATA_W-1:0]     i_rd_data,
    output logic                  o_rd_ack,
    input  logic                  i_wr_buffer_free,
    output logic                  o_wr_en,
    output logic [DATA_W-1:0]     o_wr_data,
    output logic [DATA_W-1:0]     o_leds,
    output logic [VEC_N*24-1:0]   o_vec,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int       VEC_W     = VEC_N * 24;
    localparam int       VEC_WORDS = VEC_W / DATA_W;
    localparam logic [2:0] VEC_LAST = 3'(VEC_WORDS - 1);

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_INIT    = 8'h01;
    localparam logic [7:0] OP_WR_INV  = 8'h02;
    localparam logic [7:0] OP_RD_INV  = 8'h03;
    localparam logic [7:0] OP_WR_LEDS = 8'h04;
    localparam logic [7:0] OP_RD_LEDS = 8'h05;
    localparam logic [7:0] OP_WR_VEC  = 8'h06;
    localparam logic [7:0] OP_RD_VEC  = 8'h07;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARG    = 2'd1,
        S_VEC_RX = 2'd2,
        S_TX     = 2'd3
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic                r_rda_prev;
    logic                r_pend,    w_pend_nxt;
    logic                r_rd_ack,  w_rd_ack_nxt;
    logic                r_wr_en,   w_wr_en_nxt;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
    logic [DATA_W-1:0]   r_leds,    w_leds_nxt;
    logic [DATA_W-1:0]   r_inv,     w_inv_nxt;
    logic [VEC_W-1:0]    r_vec,     w_vec_nxt;
    logic                r_err,     w_err_nxt;
    logic [2:0]          r_cnt,     w_cnt_nxt;
    logic [2:0]          r_tx_last, w_tx_last_nxt;
    logic                r_arg_leds, w_arg_leds_nxt;
    logic [VEC_W-1:0]    r_rx_buf,  w_rx_buf_nxt;
    logic [VEC_W-1:0]    r_tx_buf,  w_tx_buf_nxt;

    logic                w_edge;
    logic                w_take;
    logic                w_fire;
    logic                w_tx_done;
    logic [7:0]          w_opcode;
    logic [VEC_W-1:0]    w_rx_shift;

    // The wire stream carries element 0 first (MSB-first) while vec keeps
    // element 0 in the low bits; reversing element order maps one to the other.
    function automatic logic [VEC_W-1:0] elem_rev(input logic [VEC_W-1:0] a);
        logic [VEC_W-1:0] r;
        r = '0;
        for (int k = 0; k < VEC_N; k++) begin
            r[24*k +: 24] = a[VEC_W-24*(k+1) +: 24];
        end
        return r;
    endfunction

    always_comb begin
        w_edge     = i_rd_data_available & ~r_rda_prev;
        w_take     = (w_edge | r_pend) & ~i_ss;
        w_fire     = (r_state == S_TX) & i_wr_buffer_free & ~r_wr_en & ~i_ss;
        w_tx_done  = w_fire & (r_cnt == r_tx_last);
        w_opcode   = i_rd_data[7:0];
        w_rx_shift = {r_rx_buf[VEC_W-DATA_W-1:0], i_rd_data};

        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend;
        w_rd_ack_nxt   = 1'b0;
        w_wr_en_nxt    = 1'b0;
        w_wr_data_nxt  = r_wr_data;
        w_leds_nxt     = r_leds;
        w_inv_nxt      = r_inv;
        w_vec_nxt      = r_vec;
        w_err_nxt      = r_err;
        w_cnt_nxt      = r_cnt;
        w_tx_last_nxt  = r_tx_last;
        w_arg_leds_nxt = r_arg_leds;
        w_rx_buf_nxt   = r_rx_buf;
        w_tx_buf_nxt   = r_tx_buf;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 3'd0;
                if (w_take) begin
                    w_rd_ack_nxt = 1'b1;
                    w_pend_nxt   = 1'b0;
                    case (w_opcode)
                        OP_NOP: ;
                        OP_INIT: begin
                            w_inv_nxt  = '0;
                            w_leds_nxt = '0;
                            w_vec_nxt  = '0;
                            w_err_nxt  = 1'b0;
                        end
                        OP_WR_INV: begin
                            w_arg_leds_nxt = 1'b0;
                            w_state_nxt    = S_ARG;
                        end
                        OP_WR_LEDS: begin
                            w_arg_leds_nxt = 1'b1;
                            w_state_nxt    = S_ARG;
                        end
                        OP_RD_INV: begin
                            w_tx_buf_nxt  = {r_inv, {(VEC_W-DATA_W){1'b0}}};
                            w_tx_last_nxt = 3'd0;
                            w_state_nxt   = S_TX;
                        end
                        OP_RD_LEDS: begin
                            w_tx_buf_nxt  = {r_leds, {(VEC_W-DATA_W){1'b0}}};
                            w_tx_last_nxt = 3'd0;
                            w_state_nxt   = S_TX;
                        end
                        OP_WR_VEC: begin
                            w_state_nxt = S_VEC_RX;
                        end
                        OP_RD_VEC: begin
                            w_tx_buf_nxt  = elem_rev(r_vec);
                            w_tx_last_nxt = VEC_LAST;
                            w_state_nxt   = S_TX;
                        end
                        default: begin
                            w_err_nxt = 1'b1;
                        end
                    endcase
                end
            end

            S_ARG: begin
                if (w_take) begin
                    w_rd_ack_nxt = 1'b1;
                    if (r_arg_leds) begin
                        w_leds_nxt = i_rd_data;
                    end else begin
                        w_inv_nxt = ~i_rd_data;
                    end
                    w_state_nxt = S_IDLE;
                end
            end

            S_VEC_RX: begin
                if (w_take) begin
                    w_rd_ack_nxt = 1'b1;
                    w_rx_buf_nxt = w_rx_shift;
                    w_cnt_nxt    = r_cnt + 3'd1;
                    if (r_cnt == VEC_LAST) begin
                        w_vec_nxt   = elem_rev(w_rx_shift);
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_TX: begin
                if (w_fire) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_data_nxt = r_tx_buf[VEC_W-1 -: DATA_W];
                    w_tx_buf_nxt  = r_tx_buf << DATA_W;
                    w_cnt_nxt     = r_cnt + 3'd1;
                    if (w_tx_done) begin
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = S_IDLE;
                    end
                end
                // A word landing with the final write is an opcode for the next IDLE cycle.
                if (w_take) begin
                    if (w_tx_done) begin
                        w_pend_nxt = 1'b1;
                    end else begin
                        w_rd_ack_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (i_ss) begin
            w_state_nxt = S_IDLE;
            w_pend_nxt  = 1'b0;
            w_cnt_nxt   = 3'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_rda_prev <= 1'b1;
            r_pend     <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_leds     <= '0;
            r_inv      <= '0;
            r_vec      <= '0;
            r_err      <= 1'b0;
            r_cnt      <= 3'd0;
            r_tx_last  <= 3'd0;
            r_arg_leds <= 1'b0;
            r_rx_buf   <= '0;
            r_tx_buf   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rda_prev <= i_rd_data_available;
            r_pend     <= w_pend_nxt;
            r_rd_ack   <= w_rd_ack_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_leds     <= w_leds_nxt;
            r_inv      <= w_inv_nxt;
            r_vec      <= w_vec_nxt;
            r_err      <= w_err_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_last  <= w_tx_last_nxt;
            r_arg_leds <= w_arg_leds_nxt;
            r_rx_buf   <= w_rx_buf_nxt;
            r_tx_buf   <= w_tx_buf_nxt;
        end
    end

    assign o_rd_ack  = r_rd_ack;
    assign o_wr_en   = r_wr_en;
    assign o_wr_data = r_wr_data;
    assign o_leds    = r_leds;
    assign o_vec     = r_vec;
    assign o_busy    = (r_state != S_IDLE);
    assign o_err     = r_err;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed and randomized command sequences for spi_cmd_ctrl, checked against a byte-level register model.
module tb_spi_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ss;
    logic        rda;
    logic [15:0] rd_data;
    logic        rd_ack;
    logic        wr_free;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] leds;
    logic [95:0] vec;
    logic        busy;
    logic        err;

    spi_cmd_ctrl #(.DATA_W(16), .VEC_N(4)) dut (
        .i_clk              (clk),
        .i_reset            (rst_n),
        .i_ss               (ss),
        .i_rd_data_available(rda),
        .i_rd_data          (rd_data),
        .o_rd_ack           (rd_ack),
        .i_wr_buffer_free   (wr_free),
        .o_wr_en            (wr_en),
        .o_wr_data          (wr_data),
        .o_leds             (leds),
        .o_vec              (vec),
        .o_busy             (busy),
        .o_err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          ack_cnt = 0;
    logic        prev_wr = 1'b0;
    logic        wr_b2b = 1'b0;
    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];

    // Reference state
    logic [15:0] m_leds = '0;
    logic [15:0] m_inv = '0;
    logic [95:0] m_vec = '0;
    logic        m_err = 1'b0;
    logic [15:0] vw [6];

    always @(negedge clk) begin
        if (wr_en) begin
            wr_q.push_back(wr_data);
            if (prev_wr) wr_b2b = 1'b1;
        end
        prev_wr = wr_en;
        if (rd_ack) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] opw(input logic [7:0] op);
        logic [7:0] hi;
        hi = 8'($urandom);
        return {hi, op};
    endfunction

    task automatic send_word(input logic [15:0] w);
        @(negedge clk);
        rd_data = w;
        rda = 1'b1;
        repeat (3) @(negedge clk);
        rda = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 96'(n < 300), 96'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_tx(input string tag);
        chk({tag, "_wr_count"}, 96'(wr_q.size()), 96'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            chk({tag, "_wr_word"}, 96'(wr_q[i]), 96'(exp_q[i]));
        wr_q.delete();
        exp_q.delete();
    endtask

    // Stream bytes in arrival order; element k is bytes 3k..3k+2, most significant first.
    task automatic model_wr_vec();
        logic [7:0] b [12];
        for (int i = 0; i < 6; i++) begin
            b[2*i]   = vw[i][15:8];
            b[2*i+1] = vw[i][7:0];
        end
        for (int k = 0; k < 4; k++)
            m_vec[24*k +: 24] = {b[3*k], b[3*k+1], b[3*k+2]};
    endtask

    task automatic model_rd_vec();
        logic [7:0] b [12];
        for (int k = 0; k < 4; k++) begin
            b[3*k]   = m_vec[24*k+16 +: 8];
            b[3*k+1] = m_vec[24*k+8  +: 8];
            b[3*k+2] = m_vec[24*k    +: 8];
        end
        for (int i = 0; i < 6; i++) exp_q.push_back({b[2*i], b[2*i+1]});
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_leds"}, 96'(leds), 96'(m_leds));
        chk({tag, "_vec"}, vec, m_vec);
        chk({tag, "_err"}, 96'(err), 96'(m_err));
        chk({tag, "_busy"}, 96'(busy), 96'd0);
    endtask

    initial begin
        int a0;
        int sel;
        logic [15:0] v;

        rst_n = 1'b0; ss = 1'b0; rda = 1'b0; rd_data = '0; wr_free = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_ack", 96'(rd_ack), 96'd0);
        chk("rst_wr_en", 96'(wr_en), 96'd0);
        chk("rst_wr_data", 96'(wr_data), 96'd0);
        check_regs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write LEDs
        a0 = ack_cnt;
        send_word(16'h0004);
        send_word(16'hA5C3);
        m_leds = 16'hA5C3;
        wait_idle("wr_leds");
        chk("wr_leds_val", 96'(leds), 96'hA5C3);
        chk("wr_leds_acks", 96'(ack_cnt - a0), 96'd2);
        compare_tx("wr_leds");

        // Inverted register round trip
        a0 = ack_cnt;
        send_word(16'h0002);
        send_word(16'h1234);
        m_inv = ~16'h1234;
        send_word(16'h0003);
        send_word(16'h0000);
        exp_q.push_back(16'hEDCB);
        wait_idle("inv");
        chk("inv_acks", 96'(ack_cnt - a0), 96'd4);
        compare_tx("inv");

        // Vector write / read
        vw[0] = 16'h1122; vw[1] = 16'h3344; vw[2] = 16'h5566;
        vw[3] = 16'h7788; vw[4] = 16'h99AA; vw[5] = 16'hBBCC;
        send_word(16'h0006);
        for (int i = 0; i < 6; i++) send_word(vw[i]);
        model_wr_vec();
        wait_idle("wr_vec");
        chk("vec_elem0", 96'(vec[23:0]), 96'h112233);
        chk("vec_elem3", 96'(vec[95:72]), 96'hAABBCC);
        chk("vec_full", vec, m_vec);
        send_word(16'h0007);
        for (int i = 0; i < 6; i++) exp_q.push_back(vw[i]);
        wait_idle("rd_vec");
        compare_tx("rd_vec");

        // Partial vector write aborted by ss
        send_word(16'h0006);
        for (int i = 0; i < 3; i++) send_word(16'(16'hDEAD + i));
        chk("abort_busy_before", 96'(busy), 96'd1);
        @(negedge clk); ss = 1'b1;
        repeat (2) @(negedge clk); ss = 1'b0;
        chk("abort_busy", 96'(busy), 96'd0);
        chk("abort_vec", vec, m_vec);
        send_word(16'h0005);
        exp_q.push_back(m_leds);
        wait_idle("abort_rd_leds");
        compare_tx("abort_rd_leds");

        // Unknown opcode then INIT
        send_word(16'h00FF);
        m_err = 1'b1;
        wait_idle("bad_op");
        chk("bad_op_err", 96'(err), 96'd1);
        send_word(16'h0001);
        m_err = 1'b0; m_leds = '0; m_inv = '0; m_vec = '0;
        wait_idle("init");
        check_regs("init");

        // Transmit held off by a full buffer
        send_word(16'h0004);
        send_word(16'h3C96);
        m_leds = 16'h3C96;
        wait_idle("wr_leds2");
        wr_free = 1'b0;
        send_word(16'h0005);
        repeat (10) @(negedge clk);
        chk("hold_no_wr", 96'(wr_q.size()), 96'd0);
        chk("hold_busy", 96'(busy), 96'd1);
        wr_free = 1'b1;
        exp_q.push_back(m_leds);
        wait_idle("hold");
        compare_tx("hold");

        // Word arriving alongside the final write becomes the next opcode
        a0 = ack_cnt;
        wr_free = 1'b0;
        @(negedge clk); rd_data = opw(8'h03); rda = 1'b1;
        @(negedge clk); rda = 1'b0;
        @(negedge clk); rd_data = opw(8'h05); rda = 1'b1; wr_free = 1'b1;
        repeat (3) @(negedge clk); rda = 1'b0;
        exp_q.push_back(m_inv);
        exp_q.push_back(m_leds);
        wait_idle("coinc");
        chk("coinc_acks", 96'(ack_cnt - a0), 96'd2);
        compare_tx("coinc");

        // Randomized command mix
        for (int it = 0; it < 40; it++) begin
            int nw;
            sel = $urandom_range(0, 8);
            a0 = ack_cnt;
            v = 16'($urandom);
            nw = 1;
            case (sel)
                0: begin send_word(opw(8'h04)); send_word(v); m_leds = v; nw = 2; end
                1: begin send_word(opw(8'h02)); send_word(v); m_inv = ~v; nw = 2; end
                2: begin exp_q.push_back(m_leds); send_word(opw(8'h05)); end
                3: begin exp_q.push_back(m_inv); send_word(opw(8'h03)); end
                4: begin
                    for (int i = 0; i < 6; i++) vw[i] = 16'($urandom);
                    send_word(opw(8'h06));
                    for (int i = 0; i < 6; i++) send_word(vw[i]);
                    model_wr_vec();
                    nw = 7;
                end
                5: begin model_rd_vec(); send_word(opw(8'h07)); end
                6: send_word(opw(8'h00));
                7: begin send_word(opw(8'($urandom_range(8, 255)))); m_err = 1'b1; end
                default: begin
                    send_word(opw(8'h01));
                    m_leds = '0; m_inv = '0; m_vec = '0; m_err = 1'b0;
                end
            endcase
            wait_idle("rnd");
            chk("rnd_acks", 96'(ack_cnt - a0), 96'(nw));
            compare_tx("rnd");
            check_regs("rnd");
        end

        // Asynchronous reset in the middle of a transmit
        send_word(16'h0004);
        send_word(16'h5A5A);
        wait_idle("pre_rst");
        wr_free = 1'b0;
        send_word(16'h0007);
        chk("mid_tx_busy", 96'(busy), 96'd1);
        @(negedge clk);
        rd_data = 16'h0005; rda = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_ack", 96'(rd_ack), 96'd0);
        chk("arst_wr_en", 96'(wr_en), 96'd0);
        chk("arst_wr_data", 96'(wr_data), 96'd0);
        m_leds = '0; m_inv = '0; m_vec = '0; m_err = 1'b0;
        check_regs("arst");
        @(negedge clk);
        a0 = ack_cnt;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rel_no_consume", 96'(ack_cnt - a0), 96'd0);
        chk("rel_busy", 96'(busy), 96'd0);
        rda = 1'b0; wr_free = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_wr_in_reset", 96'(wr_q.size()), 96'd0);
        chk("wr_en_back_to_back", 96'(wr_b2b), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
